ble_crc_tx_serializer: RTL and testbench



---
 rtl/ble_crc_tx_serializer_if.sv | 22 ++
 rtl/ble_crc_tx_serializer.sv | 124 ++++++++++++
 tb/tb_ble_crc_tx_serializer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ble_crc_tx_serializer_if.sv
// Byte-in / bit-out handshake bundle for the BLE CRC transmit serializer.
// The slave modport is the serializer's view; the master modport is the driver/sink view.
interface ble_crc_tx_serializer_if;
   logic [7:0] byte_i;
   logic       byte_valid_i;
   logic       byte_last_i;
   logic       byte_ready_o;
   logic       bit_o;
   logic       bit_valid_o;
   logic       bit_ready_i;
   logic       is_crc_o;

   modport slave (
      input  byte_i, byte_valid_i, byte_last_i, bit_ready_i,
      output byte_ready_o, bit_o, bit_valid_o, is_crc_o
   );

   modport master (
      output byte_i, byte_valid_i, byte_last_i, bit_ready_i,
      input  byte_ready_o, bit_o, bit_valid_o, is_crc_o
   );
endinterface

// File: rtl/ble_crc_tx_serializer.sv
// Serializes BLE PDU bytes LSB-first while running a CRC-24 Galois LFSR over
// the outgoing bits, then appends the 24 CRC bits MSB-first.
module ble_crc_tx_serializer #(
   parameter logic [63:0] POLYNOM  = 64'h100065B,
   parameter logic [23:0] CRC_INIT = 24'h555555
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic                          init_sel_i,
   input  logic [23:0]                   init_i,
   ble_crc_tx_serializer_if.slave        bus,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [23:0]                   crc_o
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BYTE,
      DATA,
      CRC
   } state_t;

   // The x^24 term is implicit in the shift-out, so only bits 23..0 act as taps.
   localparam logic [23:0] TAPS = POLYNOM[23:0];

   state_t      r_state;
   logic [23:0] r_crc;
   logic [7:0]  r_shift;
   logic [4:0]  r_bitCount;
   logic        r_last;
   logic        r_byteReady;
   logic        r_bitValid;
   logic        r_isCrc;
   logic        r_busy;
   logic        r_done;

   logic        w_feedback;
   logic [23:0] w_crcNext;

   assign w_feedback = r_crc[23] ^ r_shift[0];
   assign w_crcNext  = {r_crc[22:0], 1'b0} ^ (TAPS & {24{w_feedback}});

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_crc       <= '0;
         r_shift     <= '0;
         r_bitCount  <= '0;
         r_last      <= 1'b0;
         r_byteReady <= 1'b0;
         r_bitValid  <= 1'b0;
         r_isCrc     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_crc       <= init_sel_i ? init_i : CRC_INIT;
                  r_state     <= WAIT_BYTE;
                  r_byteReady <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            WAIT_BYTE: begin
               if (bus.byte_valid_i) begin
                  r_shift     <= bus.byte_i;
                  r_last      <= bus.byte_last_i;
                  r_bitCount  <= '0;
                  r_state     <= DATA;
                  r_byteReady <= 1'b0;
                  r_bitValid  <= 1'b1;
               end
            end
            DATA: begin
               if (bus.bit_ready_i) begin
                  r_crc      <= w_crcNext;
                  r_shift    <= {1'b0, r_shift[7:1]};
                  r_bitCount <= r_bitCount + 5'd1;
                  if (r_bitCount == 5'd7) begin
                     r_bitCount <= '0;
                     if (r_last) begin
                        r_state <= CRC;
                        r_isCrc <= 1'b1;
                     end else begin
                        r_state     <= WAIT_BYTE;
                        r_bitValid  <= 1'b0;
                        r_byteReady <= 1'b1;
                     end
                  end
               end
            end
            CRC: begin
               // The CRC field is emitted by plain shifting; feedback is off here.
               if (bus.bit_ready_i) begin
                  r_crc      <= {r_crc[22:0], 1'b0};
                  r_bitCount <= r_bitCount + 5'd1;
                  if (r_bitCount == 5'd23) begin
                     r_bitCount <= '0;
                     r_state    <= IDLE;
                     r_bitValid <= 1'b0;
                     r_isCrc    <= 1'b0;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.byte_ready_o = r_byteReady;
   assign bus.bit_valid_o  = r_bitValid;
   assign bus.is_crc_o     = r_isCrc;
   assign bus.bit_o        = r_bitValid & (r_isCrc ? r_crc[23] : r_shift[0]);
   assign busy_o           = r_busy;
   assign done_o           = r_done;
   assign crc_o            = r_crc;

endmodule

// File: tb/tb_ble_crc_tx_serializer.sv
// Randomized self-checking bench for ble_crc_tx_serializer: a queue of expected
// bits built from a software CRC-24 model is compared against every bit transfer.
module tb_ble_crc_tx_serializer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        init_sel_i;
   logic [23:0] init_i;
   logic        busy_o;
   logic        done_o;
   logic [23:0] crc_o;

   ble_crc_tx_serializer_if bus ();

   ble_crc_tx_serializer u_dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .init_sel_i (init_sel_i),
      .init_i     (init_i),
      .bus        (bus),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .crc_o      (crc_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        b;
      logic        isCrc;
      logic        first;
      logic [23:0] crc;
   } exp_t;

   exp_t       expQ[$];
   int         assertCount = 0;
   int         failCount   = 0;
   int         xferCount   = 0;
   int         doneCount   = 0;
   bit         stallMode   = 1'b0;
   logic [7:0] pkt[8];

   task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Plain software CRC-24: shift left, xor 0x65B when the outgoing MSB differs from the data bit.
   function automatic logic [23:0] modelCrc(input int n, input logic [23:0] seed);
      int c;
      int b;
      int fb;
      c = int'(seed);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 8; k++) begin
            b  = (int'(pkt[i]) >> k) & 1;
            fb = ((c >> 23) & 1) ^ b;
            c  = ((c << 1) & 32'hFFFFFF) ^ (fb != 0 ? 32'h65B : 32'h0);
         end
      end
      return 24'(c);
   endfunction

   task automatic buildExpect(input int n, input logic [23:0] seed);
      logic [23:0] crc;
      exp_t        e;
      crc = modelCrc(n, seed);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 8; k++) begin
            e = '{b: pkt[i][k], isCrc: 1'b0, first: 1'b0, crc: 24'h0};
            expQ.push_back(e);
         end
      end
      for (int k = 23; k >= 0; k--) begin
         e = '{b: crc[k], isCrc: 1'b1, first: (k == 23), crc: crc};
         expQ.push_back(e);
      end
   endtask

   // Downstream sink: always ready, or coin-flip ready when stalling is enabled.
   initial begin
      bus.bit_ready_i = 1'b1;
      forever begin
         @(posedge clk_i);
         #1;
         bus.bit_ready_i = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Compare process: every transfer must match the head of the expected queue.
   initial begin
      logic        prevBit;
      logic [23:0] prevCrc;
      bit          prevStall;
      exp_t        e;
      prevBit   = 1'b0;
      prevCrc   = '0;
      prevStall = 1'b0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            prevStall = 1'b0;
            continue;
         end
         if (prevStall) begin
            checkOutput("stall_bit_hold", {bus.bit_valid_o, bus.bit_o}, {1'b1, prevBit});
            checkOutput("stall_crc_hold", crc_o, prevCrc);
         end
         if (bus.bit_valid_o && bus.bit_ready_i) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_bit", 48'(expQ.size()), 48'd1);
            end else begin
               e = expQ.pop_front();
               checkOutput("bit", bus.bit_o, e.b);
               checkOutput("is_crc", bus.is_crc_o, e.isCrc);
               if (e.first) checkOutput("crc_final", crc_o, e.crc);
            end
            xferCount++;
         end
         if (done_o) begin
            doneCount++;
            checkOutput("done_after_last_bit", 48'(expQ.size()), 48'd0);
         end
         checkOutput("ready_valid_exclusive", bus.byte_ready_o & bus.bit_valid_o, 1'b0);
         prevStall = bus.bit_valid_o && !bus.bit_ready_i;
         prevBit   = bus.bit_o;
         prevCrc   = crc_o;
      end
   end

   task automatic startPacket(input logic sel, input logic [23:0] seed);
      @(posedge clk_i);
      #1;
      start_i    = 1'b1;
      init_sel_i = sel;
      init_i     = seed;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      checkOutput("busy_ready_after_start", {busy_o, bus.byte_ready_o}, 2'b11);
   endtask

   task automatic sendByte(input logic [7:0] data, input logic last, input logic pulseStart);
      int t;
      bus.byte_i       = data;
      bus.byte_last_i  = last;
      bus.byte_valid_i = 1'b1;
      start_i          = pulseStart;
      t = 0;
      do begin
         @(negedge clk_i);
         t++;
      end while (!bus.byte_ready_o && t < 500);
      if (t >= 500) checkOutput("byte_accept_timeout", 48'(t), 48'd0);
      @(posedge clk_i);
      #1;
      bus.byte_valid_i = 1'b0;
      bus.byte_i       = $urandom;
      start_i          = 1'b0;
   endtask

   task automatic applyStimulus(input int n, input logic sel, input logic [23:0] seed,
                                input bit stall, input bit pulse);
      int xBase;
      int dBase;
      int t;
      xBase     = xferCount;
      dBase     = doneCount;
      stallMode = stall;
      buildExpect(n, sel ? seed : 24'h555555);
      startPacket(sel, seed);
      for (int i = 0; i < n; i++) sendByte(pkt[i], (i == n - 1), pulse && (i == 1));
      t = 0;
      while (doneCount == dBase && t < 5000) begin
         @(negedge clk_i);
         t++;
      end
      repeat (3) @(negedge clk_i);
      checkOutput("done_pulse_count", 48'(doneCount - dBase), 48'd1);
      checkOutput("transfer_count", 48'(xferCount - xBase), 48'(8 * n + 24));
      checkOutput("idle_after_packet", {busy_o, bus.bit_valid_o, crc_o}, 26'h0);
      expQ.delete();
      stallMode = 1'b0;
   endtask

   initial begin
      int xBase;
      int dBase;
      int t;
      rst_i            = 1'b1;
      start_i          = 1'b0;
      init_sel_i       = 1'b0;
      init_i           = '0;
      bus.byte_i       = '0;
      bus.byte_valid_i = 1'b0;
      bus.byte_last_i  = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // Hand-computed anchors for the reference model itself.
      pkt[0] = 8'h01;
      checkOutput("model_pin_01", modelCrc(1, 24'h0), 24'h032D80);
      pkt[0] = 8'h00;
      checkOutput("model_pin_00", modelCrc(1, 24'h0), 24'h000000);
      pkt[0] = 8'h80;
      checkOutput("model_pin_80", modelCrc(1, 24'h0), 24'h00065B);

      repeat (10) begin
         @(negedge clk_i);
         checkOutput("reset_idle_outputs",
                     {bus.bit_valid_o, bus.bit_o, bus.is_crc_o, busy_o, done_o, bus.byte_ready_o, crc_o},
                     30'h0);
      end

      pkt[0] = 8'h01;
      applyStimulus(1, 1'b1, 24'h0, 1'b0, 1'b0);
      pkt[0] = 8'h00;
      applyStimulus(1, 1'b1, 24'h0, 1'b0, 1'b0);
      pkt[0] = 8'h01;
      applyStimulus(1, 1'b1, 24'h0, 1'b1, 1'b0);
      pkt[0] = 8'hA5;
      pkt[1] = 8'h3C;
      applyStimulus(2, 1'b0, 24'h123456, 1'b0, 1'b1);

      // Reset in the middle of the first data byte.
      xBase  = xferCount;
      dBase  = doneCount;
      pkt[0] = 8'hFF;
      pkt[1] = 8'h12;
      buildExpect(2, 24'h555555);
      startPacket(1'b0, 24'h0);
      bus.byte_i       = pkt[0];
      bus.byte_last_i  = 1'b0;
      bus.byte_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.byte_valid_i = 1'b0;
      t = 0;
      while (xferCount < xBase + 5 && t < 200) begin
         @(negedge clk_i);
         t++;
      end
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("mid_reset_outputs",
                  {busy_o, bus.bit_valid_o, done_o, bus.byte_ready_o, crc_o}, 28'h0);
      expQ.delete();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checkOutput("mid_reset_no_done", 48'(doneCount - dBase), 48'd0);

      pkt[0] = 8'h01;
      applyStimulus(1, 1'b1, 24'h0, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
         applyStimulus(n, 1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
